// File: rtl/if_prefetch_queue.sv
// Fetch stage with a small prefetch queue feeding IF_ID.
// Owns the fetch PC, reads instruction memory, and flushes on redirects from ID.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              imem_addr,
    output logic                     imem_req,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     id_ready,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc_incr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc_incr;
        logic [31:0] instr;
    } entry_t;

    entry_t             storage [DEPTH];
    logic [31:0]        fetch_pc;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    entry_t             head;

    // Queue handshake: a pop frees a slot for a same-cycle push when full.
    always_comb begin
        pop  = 1'b0;
        push = 1'b0;
        pop  = id_ready && (count != CNT_W'(0));
        push = !redirect && ((count < CNT_W'(DEPTH)) || pop);
    end

    assign imem_req  = push;
    assign imem_addr = fetch_pc;

    // Control state: fetch PC, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage is never cleared; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            storage[wr_ptr] <= '{pc_incr: fetch_pc + 32'd4, instr: imem_rdata};
        end
    end

    assign head        = storage[rd_ptr];
    assign out_valid   = (count != CNT_W'(0));
    assign out_instr   = out_valid ? head.instr   : 32'd0;
    assign out_pc_incr = out_valid ? head.pc_incr : 32'd0;

endmodule
